// File: rtl/pzcorebus_mux_controller.sv
// Select generator for the pzcorebus N:1 mux: round-robin command arbitration,
// with in-order routing of write data and responses back to the owning slave.
module pzcorebus_mux_controller #(
  parameter int SLAVES              = 2,
  parameter int LENGTH_WIDTH        = 8,
  parameter int WDATA_FIFO_DEPTH    = 4,
  parameter int RESPONSE_FIFO_DEPTH = 8
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic [SLAVES-1:0]                i_mcmd_valid,
  input  logic [SLAVES-1:0]                i_mcmd_with_data,
  input  logic [SLAVES-1:0]                i_mcmd_non_posted,
  input  logic [SLAVES*LENGTH_WIDTH-1:0]   i_mcmd_data_count,
  input  logic                             i_master_scmd_accept,
  input  logic [SLAVES-1:0]                i_mdata_valid,
  input  logic                             i_master_sdata_accept,
  input  logic                             i_master_sresp_valid,
  input  logic                             i_master_mresp_accept,
  input  logic                             i_master_sresp_last,
  output logic [SLAVES-1:0]                o_command_select,
  output logic [SLAVES-1:0]                o_write_data_select,
  output logic [SLAVES-1:0]                o_response_select,
  output logic                             o_unexpected_response
);

  localparam int IDXW = (SLAVES > 1) ? $clog2(SLAVES) : 1;
  localparam int WPW  = $clog2(WDATA_FIFO_DEPTH);
  localparam int WCW  = WPW + 1;
  localparam int RPW  = $clog2(RESPONSE_FIFO_DEPTH);
  localparam int RCW  = RPW + 1;

  typedef enum logic [0:0] {
    STATE_IDLE    = 1'b0,
    STATE_GRANTED = 1'b1
  } state_e;

  function automatic logic [SLAVES-1:0] idx_to_onehot(input logic [IDXW-1:0] idx);
    logic [SLAVES-1:0] oh;
    for (int i = 0; i < SLAVES; i++) begin
      oh[i] = (idx == IDXW'(i));
    end
    return oh;
  endfunction

  // command arbiter state
  state_e                  state_q, state_d;
  logic [IDXW-1:0]         grant_q, grant_d;
  logic [IDXW-1:0]         rr_q, rr_d;
  logic [SLAVES-1:0]       cmd_sel_q, cmd_sel_d;

  // write-data tracking FIFO: owner index and beats-1 per accepted burst
  logic [WDATA_FIFO_DEPTH-1:0][IDXW-1:0]         wfifo_idx_q, wfifo_idx_d;
  logic [WDATA_FIFO_DEPTH-1:0][LENGTH_WIDTH-1:0] wfifo_len_q, wfifo_len_d;
  logic [WPW-1:0]          wwr_ptr_q, wwr_ptr_d;
  logic [WPW-1:0]          wrd_ptr_q, wrd_ptr_d;
  logic [WCW-1:0]          wcount_q, wcount_d;
  logic [LENGTH_WIDTH-1:0] beat_q, beat_d;
  logic [SLAVES-1:0]       wsel_q, wsel_d;

  // response tracking FIFO: owner index per outstanding non-posted command
  logic [RESPONSE_FIFO_DEPTH-1:0][IDXW-1:0]      rfifo_idx_q, rfifo_idx_d;
  logic [RPW-1:0]          rwr_ptr_q, rwr_ptr_d;
  logic [RPW-1:0]          rrd_ptr_q, rrd_ptr_d;
  logic [RCW-1:0]          rcount_q, rcount_d;
  logic [SLAVES-1:0]       rsel_q, rsel_d;

  logic                    unexp_q, unexp_d;

  logic                    wfull_s, rfull_s;
  logic [SLAVES-1:0]       eligible_s;
  logic                    arb_found_s;
  logic [IDXW-1:0]         arb_idx_s;
  logic                    cmd_hs_s, wpush_s, rpush_s;
  logic [LENGTH_WIDTH-1:0] push_len_s;
  logic [IDXW-1:0]         whead_idx_s;
  logic [LENGTH_WIDTH-1:0] whead_len_s;
  logic                    wbeat_s, wpop_s, rpop_s;

  assign wfull_s     = (wcount_q == WCW'(WDATA_FIFO_DEPTH));
  assign rfull_s     = (rcount_q == RCW'(RESPONSE_FIFO_DEPTH));
  assign eligible_s  = i_mcmd_valid
                     & ~(i_mcmd_with_data  & {SLAVES{wfull_s}})
                     & ~(i_mcmd_non_posted & {SLAVES{rfull_s}});

  assign cmd_hs_s    = (state_q == STATE_GRANTED) & i_mcmd_valid[grant_q] & i_master_scmd_accept;
  assign wpush_s     = cmd_hs_s & i_mcmd_with_data[grant_q];
  assign rpush_s     = cmd_hs_s & i_mcmd_non_posted[grant_q];
  assign push_len_s  = i_mcmd_data_count[int'(grant_q)*LENGTH_WIDTH +: LENGTH_WIDTH];

  assign whead_idx_s = wfifo_idx_q[wrd_ptr_q];
  assign whead_len_s = wfifo_len_q[wrd_ptr_q];
  assign wbeat_s     = (wcount_q != '0) & i_mdata_valid[whead_idx_s] & i_master_sdata_accept;
  assign wpop_s      = wbeat_s & (beat_q == whead_len_s);
  assign rpop_s      = (rcount_q != '0) & i_master_sresp_valid & i_master_mresp_accept
                     & i_master_sresp_last;

  // Round-robin search: first eligible slave at or after the pointer, wrapping.
  always_comb begin
    int  sum;
    int  cand;
    logic take;
    arb_found_s = 1'b0;
    arb_idx_s   = '0;
    sum         = 0;
    cand        = 0;
    take        = 1'b0;
    for (int k = 0; k < SLAVES; k++) begin
      sum         = int'(rr_q) + k;
      cand        = (sum >= SLAVES) ? (sum - SLAVES) : sum;
      take        = ~arb_found_s & eligible_s[cand];
      arb_idx_s   = take ? IDXW'(cand) : arb_idx_s;
      arb_found_s = arb_found_s | take;
    end
  end

  // Command FSM next state and registered command select.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    cmd_sel_d = cmd_sel_q;
    case (state_q)
      STATE_IDLE: begin
        if (arb_found_s) begin
          state_d   = STATE_GRANTED;
          grant_d   = arb_idx_s;
          cmd_sel_d = idx_to_onehot(arb_idx_s);
        end else begin
          cmd_sel_d = '0;
        end
      end
      STATE_GRANTED: begin
        // a dropped valid without handshake keeps the grant
        if (cmd_hs_s) begin
          state_d   = STATE_IDLE;
          rr_d      = (grant_q == IDXW'(SLAVES - 1)) ? '0 : (grant_q + IDXW'(1));
          cmd_sel_d = '0;
        end else begin
          cmd_sel_d = idx_to_onehot(grant_q);
        end
      end
      default: begin
        state_d   = STATE_IDLE;
        cmd_sel_d = '0;
      end
    endcase
  end

  // Write FIFO update, beat counting and next write-data select.
  always_comb begin
    wfifo_idx_d = wfifo_idx_q;
    wfifo_len_d = wfifo_len_q;
    wfifo_idx_d[wwr_ptr_q] = wpush_s ? grant_q    : wfifo_idx_q[wwr_ptr_q];
    wfifo_len_d[wwr_ptr_q] = wpush_s ? push_len_s : wfifo_len_q[wwr_ptr_q];
    wwr_ptr_d   = wpush_s ? (wwr_ptr_q + WPW'(1)) : wwr_ptr_q;
    wrd_ptr_d   = wpop_s  ? (wrd_ptr_q + WPW'(1)) : wrd_ptr_q;
    case ({wpush_s, wpop_s})
      2'b10:   wcount_d = wcount_q + WCW'(1);
      2'b01:   wcount_d = wcount_q - WCW'(1);
      default: wcount_d = wcount_q;
    endcase
    beat_d = wpop_s ? '0 : (wbeat_s ? (beat_q + LENGTH_WIDTH'(1)) : beat_q);
    wsel_d = (wcount_d != '0) ? idx_to_onehot(wfifo_idx_d[wrd_ptr_d]) : '0;
  end

  // Response FIFO update, next response select and sticky unexpected flag.
  always_comb begin
    rfifo_idx_d = rfifo_idx_q;
    rfifo_idx_d[rwr_ptr_q] = rpush_s ? grant_q : rfifo_idx_q[rwr_ptr_q];
    rwr_ptr_d   = rpush_s ? (rwr_ptr_q + RPW'(1)) : rwr_ptr_q;
    rrd_ptr_d   = rpop_s  ? (rrd_ptr_q + RPW'(1)) : rrd_ptr_q;
    case ({rpush_s, rpop_s})
      2'b10:   rcount_d = rcount_q + RCW'(1);
      2'b01:   rcount_d = rcount_q - RCW'(1);
      default: rcount_d = rcount_q;
    endcase
    rsel_d  = (rcount_d != '0) ? idx_to_onehot(rfifo_idx_d[rrd_ptr_d]) : '0;
    unexp_d = unexp_q | (i_master_sresp_valid & (rcount_q == '0));
  end

  // State registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= STATE_IDLE;
      grant_q     <= '0;
      rr_q        <= '0;
      cmd_sel_q   <= '0;
      wfifo_idx_q <= '0;
      wfifo_len_q <= '0;
      wwr_ptr_q   <= '0;
      wrd_ptr_q   <= '0;
      wcount_q    <= '0;
      beat_q      <= '0;
      wsel_q      <= '0;
      rfifo_idx_q <= '0;
      rwr_ptr_q   <= '0;
      rrd_ptr_q   <= '0;
      rcount_q    <= '0;
      rsel_q      <= '0;
      unexp_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_q        <= rr_d;
      cmd_sel_q   <= cmd_sel_d;
      wfifo_idx_q <= wfifo_idx_d;
      wfifo_len_q <= wfifo_len_d;
      wwr_ptr_q   <= wwr_ptr_d;
      wrd_ptr_q   <= wrd_ptr_d;
      wcount_q    <= wcount_d;
      beat_q      <= beat_d;
      wsel_q      <= wsel_d;
      rfifo_idx_q <= rfifo_idx_d;
      rwr_ptr_q   <= rwr_ptr_d;
      rrd_ptr_q   <= rrd_ptr_d;
      rcount_q    <= rcount_d;
      rsel_q      <= rsel_d;
      unexp_q     <= unexp_d;
    end
  end

  assign o_command_select      = cmd_sel_q;
  assign o_write_data_select   = wsel_q;
  assign o_response_select     = rsel_q;
  assign o_unexpected_response = unexp_q;

endmodule
